// File: rtl/apb_master_fsm29.sv
// apb_master_fsm29: APB requester stage.
// Takes one read/write command at a time from a valid/ready command channel,
// runs the APB SETUP and ACCESS phases, and returns read data and error status
// on a valid/ready response channel.
// Optional feature: define APB29_TIMEOUT_EN to abort ACCESS phases where
// pready29 stays low for TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES is only used in
// that build. Without the macro, ACCESS waits forever and rsp_timeout29 is 0.
module apb_master_fsm29 #(
  parameter int PADDR_WIDTH29  = 32,
  parameter int PWDATA_WIDTH29 = 32,
  parameter int PRDATA_WIDTH29 = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      pclock29,
  input  logic                      preset29,
  input  logic                      cmd_valid29,
  output logic                      cmd_ready29,
  input  logic                      cmd_write29,
  input  logic [PADDR_WIDTH29-1:0]  cmd_addr29,
  input  logic [PWDATA_WIDTH29-1:0] cmd_wdata29,
  input  logic [3:0]                cmd_slave29,
  output logic                      rsp_valid29,
  input  logic                      rsp_ready29,
  output logic [PRDATA_WIDTH29-1:0] rsp_rdata29,
  output logic                      rsp_slverr29,
  output logic                      rsp_timeout29,
  output logic [PADDR_WIDTH29-1:0]  paddr29,
  output logic                      prwd29,
  output logic [PWDATA_WIDTH29-1:0] pwdata29,
  output logic [15:0]               psel29,
  output logic                      penable29,
  input  logic [PRDATA_WIDTH29-1:0] prdata29,
  input  logic                      pready29,
  input  logic                      pslverr29
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state;

`ifdef APB29_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
`else
  assign rsp_timeout29 = 1'b0;
`endif

  // Commands are only taken in IDLE. Reset also masks ready, because the
  // state register already reads IDLE while reset is still being held.
  assign cmd_ready29 = (state == IDLE) && !preset29;

  // Main sequencer: owns the state, every APB output and every response
  // output. Reset drops an in-flight transfer without producing a response.
  always_ff @(posedge pclock29) begin
    if (preset29) begin
      state        <= IDLE;
      paddr29      <= '0;
      prwd29       <= 1'b0;
      pwdata29     <= '0;
      psel29       <= '0;
      penable29    <= 1'b0;
      rsp_valid29  <= 1'b0;
      rsp_rdata29  <= '0;
      rsp_slverr29 <= 1'b0;
`ifdef APB29_TIMEOUT_EN
      rsp_timeout29 <= 1'b0;
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid29) begin
            paddr29   <= cmd_addr29;
            pwdata29  <= cmd_wdata29;
            prwd29    <= cmd_write29;
            psel29    <= 16'h1 << cmd_slave29;
            penable29 <= 1'b0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          penable29 <= 1'b1;
`ifdef APB29_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          state     <= ACCESS;
        end

        ACCESS: begin
          // The address, direction, data and select lines are not assigned
          // here, so they hold. prdata29 and pslverr29 only count while
          // pready29 is high.
          if (pready29) begin
            rsp_rdata29  <= prwd29 ? '0 : prdata29;
            rsp_slverr29 <= pslverr29;
`ifdef APB29_TIMEOUT_EN
            rsp_timeout29 <= 1'b0;
`endif
            psel29       <= '0;
            penable29    <= 1'b0;
            rsp_valid29  <= 1'b1;
            state        <= RESP;
          end
`ifdef APB29_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rsp_rdata29   <= '0;
            rsp_slverr29  <= 1'b1;
            rsp_timeout29 <= 1'b1;
            psel29        <= '0;
            penable29     <= 1'b0;
            rsp_valid29   <= 1'b1;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready29) begin
            rsp_valid29 <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_fsm29.sv
// tb_apb_master_fsm29: self-checking bench for apb_master_fsm29.
// Runs a directed vector table, a mid-transfer reset sequence, and random
// transfers. Expected values for the random transfers come from a
// transaction-level model.
module tb_apb_master_fsm29;

  localparam int TMO = 8;
`ifdef APB29_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        pclock29;
  logic        preset29;
  logic        cmd_valid29;
  logic        cmd_ready29;
  logic        cmd_write29;
  logic [31:0] cmd_addr29;
  logic [31:0] cmd_wdata29;
  logic [3:0]  cmd_slave29;
  logic        rsp_valid29;
  logic        rsp_ready29;
  logic [31:0] rsp_rdata29;
  logic        rsp_slverr29;
  logic        rsp_timeout29;
  logic [31:0] paddr29;
  logic        prwd29;
  logic [31:0] pwdata29;
  logic [15:0] psel29;
  logic        penable29;
  logic [31:0] prdata29;
  logic        pready29;
  logic        pslverr29;

  apb_master_fsm29 #(.TIMEOUT_CYCLES(TMO)) dut (
    .pclock29     (pclock29),
    .preset29     (preset29),
    .cmd_valid29  (cmd_valid29),
    .cmd_ready29  (cmd_ready29),
    .cmd_write29  (cmd_write29),
    .cmd_addr29   (cmd_addr29),
    .cmd_wdata29  (cmd_wdata29),
    .cmd_slave29  (cmd_slave29),
    .rsp_valid29  (rsp_valid29),
    .rsp_ready29  (rsp_ready29),
    .rsp_rdata29  (rsp_rdata29),
    .rsp_slverr29 (rsp_slverr29),
    .rsp_timeout29(rsp_timeout29),
    .paddr29      (paddr29),
    .prwd29       (prwd29),
    .pwdata29     (pwdata29),
    .psel29       (psel29),
    .penable29    (penable29),
    .prdata29     (prdata29),
    .pready29     (pready29),
    .pslverr29    (pslverr29)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  slave;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_slverr;
    logic        exp_timeout;
    logic [15:0] exp_psel;
    int          exp_access;
  } vec_t;

  int nChecks = 0;
  int nFail   = 0;
  int edges   = 0;

  // Free-running APB clock. Outputs are sampled on the falling edge.
  initial begin
    pclock29 = 1'b0;
    forever #5 pclock29 = ~pclock29;
  end

  // Stop the run if it ever hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge pclock29);
    edges++;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] slave, input int waits, input logic [31:0] prdata,
                                 input logic slverr, input int stall, input logic [31:0] exp_rdata,
                                 input logic exp_slverr, input logic exp_timeout,
                                 input logic [15:0] exp_psel, input int exp_access);
    vec_t v;
    v.write = write; v.addr = addr; v.wdata = wdata; v.slave = slave;
    v.waits = waits; v.prdata = prdata; v.slverr = slverr; v.stall = stall;
    v.exp_rdata = exp_rdata; v.exp_slverr = exp_slverr; v.exp_timeout = exp_timeout;
    v.exp_psel = exp_psel; v.exp_access = exp_access;
    return v;
  endfunction

  // Transaction-level reference: works out the expected response from the
  // command and how the slave behaved, with no knowledge of the sequencer.
  function automatic vec_t modelTxn(input vec_t v);
    vec_t r;
    bit tmo;
    r = v;
    tmo = TMO_ON && (v.waits >= TMO);
    r.exp_psel = '0;
    r.exp_psel[v.slave] = 1'b1;
    r.exp_timeout = tmo;
    r.exp_slverr = tmo ? 1'b1 : v.slverr;
    r.exp_rdata = (tmo || v.write) ? 32'h0 : v.prdata;
    r.exp_access = tmo ? TMO : v.waits + 1;
    return r;
  endfunction

  // Runs one complete transfer. It starts and ends on a falling edge with
  // the DUT idle. During backpressure it holds a second command pending.
  task automatic applyStimulus(input vec_t v);
    int high;
    int i;
    edges = 0;
    rsp_ready29 = 1'b0;
    pready29    = 1'b0;
    cmd_valid29 = 1'b1;
    cmd_write29 = v.write;
    cmd_addr29  = v.addr;
    cmd_wdata29 = v.wdata;
    cmd_slave29 = v.slave;
    checkOutput("idle_cmd_ready", 64'(cmd_ready29), 64'(1));
    tick();
    cmd_valid29 = 1'b0;
    checkOutput("setup_psel", 64'(psel29), 64'(v.exp_psel));
    checkOutput("setup_penable", 64'(penable29), 64'(0));
    checkOutput("setup_paddr", 64'(paddr29), 64'(v.addr));
    checkOutput("setup_prwd", 64'(prwd29), 64'(v.write));
    checkOutput("setup_pwdata", 64'(pwdata29), 64'(v.wdata));
    checkOutput("setup_cmd_ready", 64'(cmd_ready29), 64'(0));
    tick();
    high = 0;
    i = 0;
    while (!rsp_valid29 && i < 64) begin
      if (penable29 && psel29 == v.exp_psel && paddr29 == v.addr &&
          prwd29 == v.write && pwdata29 == v.wdata)
        high++;
      pready29  = (i == v.waits);
      prdata29  = pready29 ? v.prdata : ~v.prdata;
      pslverr29 = pready29 ? v.slverr : ~v.slverr;
      tick();
      i++;
    end
    pready29  = 1'b0;
    pslverr29 = 1'b0;
    checkOutput("access_cycles", 64'(high), 64'(v.exp_access));
    checkOutput("rsp_valid", 64'(rsp_valid29), 64'(1));
    checkOutput("rsp_rdata", 64'(rsp_rdata29), 64'(v.exp_rdata));
    checkOutput("rsp_slverr", 64'(rsp_slverr29), 64'(v.exp_slverr));
    checkOutput("rsp_timeout", 64'(rsp_timeout29), 64'(v.exp_timeout));
    checkOutput("resp_psel", 64'(psel29), 64'(0));
    checkOutput("resp_penable", 64'(penable29), 64'(0));
    checkOutput("resp_cmd_ready", 64'(cmd_ready29), 64'(0));
    for (int s = 0; s < v.stall; s++) begin
      cmd_valid29 = 1'b1;
      tick();
      checkOutput("bp_rsp_valid", 64'(rsp_valid29), 64'(1));
      checkOutput("bp_rsp_rdata", 64'(rsp_rdata29), 64'(v.exp_rdata));
      checkOutput("bp_rsp_slverr", 64'(rsp_slverr29), 64'(v.exp_slverr));
      checkOutput("bp_rsp_timeout", 64'(rsp_timeout29), 64'(v.exp_timeout));
      checkOutput("bp_cmd_ready", 64'(cmd_ready29), 64'(0));
      checkOutput("bp_psel", 64'(psel29), 64'(0));
    end
    cmd_valid29 = 1'b0;
    rsp_ready29 = 1'b1;
    tick();
    rsp_ready29 = 1'b0;
    checkOutput("done_rsp_valid", 64'(rsp_valid29), 64'(0));
    checkOutput("done_cmd_ready", 64'(cmd_ready29), 64'(1));
    checkOutput("done_paddr_kept", 64'(paddr29), 64'(v.addr));
    checkOutput("done_pwdata_kept", 64'(pwdata29), 64'(v.wdata));
    checkOutput("txn_cycles", 64'(edges), 64'(3 + v.exp_access + v.stall));
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    preset29 = 1'b1;
    cmd_valid29 = 1'b0; cmd_write29 = 1'b0; cmd_addr29 = '0; cmd_wdata29 = '0;
    cmd_slave29 = '0; rsp_ready29 = 1'b0; prdata29 = '0; pready29 = 1'b0; pslverr29 = 1'b0;

    // Directed vectors: write, read with wait states, error read,
    // error write under backpressure, and a read to the top address.
    tbl.push_back(mkVec(1'b1, 32'h10, 32'hA5A5_0001, 4'd3, 0, 32'h1234_5678, 1'b0, 0,
                        32'h0, 1'b0, 1'b0, 16'h0008, 1));
    tbl.push_back(mkVec(1'b0, 32'h20, 32'h0, 4'd0, 3, 32'hDEAD_BEEF, 1'b0, 0,
                        32'hDEAD_BEEF, 1'b0, 1'b0, 16'h0001, 4));
    tbl.push_back(mkVec(1'b0, 32'h30, 32'h5555_AAAA, 4'd15, 1, 32'hCAFE_0000, 1'b1, 0,
                        32'hCAFE_0000, 1'b1, 1'b0, 16'h8000, 2));
    tbl.push_back(mkVec(1'b1, 32'h44, 32'h0BAD_F00D, 4'd7, 0, 32'hFFFF_FFFF, 1'b1, 5,
                        32'h0, 1'b1, 1'b0, 16'h0080, 1));
    tbl.push_back(mkVec(1'b0, 32'hFFFF_FFFC, 32'h1, 4'd9, 2, 32'h0, 1'b0, 1,
                        32'h0, 1'b0, 1'b0, 16'h0200, 3));
`ifdef APB29_TIMEOUT_EN
    // pready29 arrives on the last allowed cycle, then pready29 never arrives.
    tbl.push_back(mkVec(1'b0, 32'h50, 32'h0, 4'd2, 7, 32'h1357_9BDF, 1'b0, 0,
                        32'h1357_9BDF, 1'b0, 1'b0, 16'h0004, 8));
    tbl.push_back(mkVec(1'b0, 32'h60, 32'h0, 4'd1, 1000, 32'hFFFF_0000, 1'b0, 2,
                        32'h0, 1'b1, 1'b1, 16'h0002, 8));
`endif

    // Reset state
    tick();
    tick();
    checkOutput("rst_paddr", 64'(paddr29), 64'(0));
    checkOutput("rst_pwdata", 64'(pwdata29), 64'(0));
    checkOutput("rst_prwd", 64'(prwd29), 64'(0));
    checkOutput("rst_psel", 64'(psel29), 64'(0));
    checkOutput("rst_penable", 64'(penable29), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rsp_valid29), 64'(0));
    checkOutput("rst_rsp_rdata", 64'(rsp_rdata29), 64'(0));
    checkOutput("rst_rsp_slverr", 64'(rsp_slverr29), 64'(0));
    checkOutput("rst_rsp_timeout", 64'(rsp_timeout29), 64'(0));
    checkOutput("rst_cmd_ready", 64'(cmd_ready29), 64'(0));
    preset29 = 1'b0;
    tick();
    checkOutput("post_rst_cmd_ready", 64'(cmd_ready29), 64'(1));

    foreach (tbl[k]) applyStimulus(tbl[k]);

    // Reset pulse in the middle of ACCESS.
    cmd_valid29 = 1'b1; cmd_write29 = 1'b0; cmd_addr29 = 32'h88;
    cmd_wdata29 = 32'h7777_7777; cmd_slave29 = 4'd5;
    tick();
    cmd_valid29 = 1'b0;
    tick();
    checkOutput("mid_penable", 64'(penable29), 64'(1));
    tick();
    preset29 = 1'b1;
    tick();
    checkOutput("mid_rst_psel", 64'(psel29), 64'(0));
    checkOutput("mid_rst_penable", 64'(penable29), 64'(0));
    checkOutput("mid_rst_rsp_valid", 64'(rsp_valid29), 64'(0));
    checkOutput("mid_rst_cmd_ready", 64'(cmd_ready29), 64'(0));
    checkOutput("mid_rst_paddr", 64'(paddr29), 64'(0));
    preset29 = 1'b0;
    pready29 = 1'b1;
    tick();
    checkOutput("mid_idle_cmd_ready", 64'(cmd_ready29), 64'(1));
    tick();
    pready29 = 1'b0;
    checkOutput("mid_no_rsp", 64'(rsp_valid29), 64'(0));
    checkOutput("mid_no_psel", 64'(psel29), 64'(0));

    // Random transfers checked against the model.
    for (int n = 0; n < 24; n++) begin
      rv.write  = 1'($urandom);
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.slave  = 4'($urandom);
      rv.waits  = int'($urandom_range(0, 5));
      rv.prdata = $urandom;
      rv.slverr = ($urandom_range(0, 3) == 0);
      rv.stall  = int'($urandom_range(0, 3));
      applyStimulus(modelTxn(rv));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
